// File: rtl/RVS192_package.sv
// Shared types for the IL1 slice.
package RVS192_package;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    CLEAR  = 3'd2,
    ACK    = 3'd3,
    REFILL = 3'd4
  } il1_inc_state_t;
endpackage

// File: rtl/RVS192_user_parameters.sv
// User-tunable IL1 geometry defaults shared by the cache slice.
package RVS192_user_parameters;
  localparam int ICACHE_LINE = 128;
  localparam int ICACHE_WAY  = 4;
endpackage

// File: rtl/il1_inv_select.sv
// Pending L2 invalidations and requester choice; IL1_INV_RR_EN selects
// round-robin arbitration, otherwise inst always wins.
module il1_inv_select #(
  parameter int IDX_W = 7
) (
  input  logic             clk_l1,
  input  logic             rst_n,
  input  logic             inst_req,
  input  logic             data_req,
  input  logic [IDX_W-1:0] inst_index,
  input  logic [IDX_W-1:0] data_index,
  input  logic             take,
  input  logic             clr_inst,
  input  logic             clr_data,
  output logic             any_req,
  output logic             pick_data,
  output logic [IDX_W-1:0] pick_index,
  output logic             pend
);

  logic             inst_pend;
  logic             data_pend;
  logic [IDX_W-1:0] inst_idx_q;
  logic [IDX_W-1:0] data_idx_q;
  logic             inst_eff;
  logic             data_eff;

  // A fresh pulse is visible the same cycle so IDLE can start at once.
  assign inst_eff = inst_pend | inst_req;
  assign data_eff = data_pend | data_req;
  assign any_req  = inst_eff | data_eff;
  assign pend     = inst_pend | data_pend;

`ifdef IL1_INV_RR_EN
  logic rr_q;

  // Pointer moves only when the choice was actually contested.
  always_ff @(posedge clk_l1 or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= 1'b0;
    end else if (take && inst_eff && data_eff) begin
      rr_q <= ~rr_q;
    end
  end

  assign pick_data = data_eff & (~inst_eff | rr_q);
`else
  assign pick_data = data_eff & ~inst_eff;
`endif

  always_comb begin
    pick_index = inst_pend ? inst_idx_q : inst_index;
    if (pick_data) begin
      pick_index = data_pend ? data_idx_q : data_index;
    end
  end

  always_ff @(posedge clk_l1 or negedge rst_n) begin
    if (!rst_n) begin
      inst_pend  <= 1'b0;
      data_pend  <= 1'b0;
      inst_idx_q <= '0;
      data_idx_q <= '0;
    end else begin
      inst_pend <= inst_pend ? ~clr_inst : inst_req;
      data_pend <= data_pend ? ~clr_data : data_req;
      if (inst_req && !inst_pend) begin
        inst_idx_q <= inst_index;
      end
      if (data_req && !data_pend) begin
        data_idx_q <= data_index;
      end
    end
  end

endmodule

// File: rtl/il1_inclusion_arbiter.sv
// IL1 update-port arbiter: L2 inclusion invalidations vs. miss refill.
// Optional macro IL1_INV_RR_EN enables round-robin invalidation choice.
module il1_inclusion_arbiter
  import RVS192_package::*;
#(
  parameter int  ICACHE_LINE = RVS192_user_parameters::ICACHE_LINE,
  parameter int  ICACHE_WAY  = RVS192_user_parameters::ICACHE_WAY,
  localparam int IDX_W       = $clog2(ICACHE_LINE)
) (
  input  logic                  clk_l1,
  input  logic                  rst_n,
  input  logic                  miss_req,
  input  logic                  refill_done,
  input  logic                  inst_replace_req,
  input  logic                  data_replace_req,
  input  logic [IDX_W-1:0]      inst_index,
  input  logic [IDX_W-1:0]      data_index,
  input  logic [ICACHE_WAY-1:0] tag_hit_inst,
  input  logic [ICACHE_WAY-1:0] tag_hit_data,
  input  logic                  L2_inst_il1_ack,
  input  logic                  L2_data_il1_ack,
  output logic                  refill_grant,
  output logic                  change_index_sel,
  output logic [IDX_W-1:0]      inclusive_index,
  output logic [ICACHE_WAY-1:0] l2_clear_way,
  output logic                  inst_replace_il1_ack,
  output logic                  data_replace_il1_ack,
  output logic                  busy
);

  il1_inc_state_t   state;
  il1_inc_state_t   state_n;
  logic             sel_data;
  logic             take;
  logic             clr_inst;
  logic             clr_data;
  logic             any_req;
  logic             pick_data;
  logic [IDX_W-1:0] pick_index;
  logic             pend;
  logic             l2_ack;

  il1_inv_select #(
    .IDX_W (IDX_W)
  ) u_sel (
    .clk_l1     (clk_l1),
    .rst_n      (rst_n),
    .inst_req   (inst_replace_req),
    .data_req   (data_replace_req),
    .inst_index (inst_index),
    .data_index (data_index),
    .take       (take),
    .clr_inst   (clr_inst),
    .clr_data   (clr_data),
    .any_req    (any_req),
    .pick_data  (pick_data),
    .pick_index (pick_index),
    .pend       (pend)
  );

  assign l2_ack = sel_data ? L2_data_il1_ack : L2_inst_il1_ack;

  always_comb begin
    state_n  = state;
    take     = 1'b0;
    clr_inst = 1'b0;
    clr_data = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          take    = 1'b1;
          state_n = LOOKUP;
        end else if (miss_req) begin
          state_n = REFILL;
        end
      end
      LOOKUP: state_n = CLEAR;
      CLEAR: begin
        clr_inst = ~sel_data;
        clr_data = sel_data;
        state_n  = ACK;
      end
      ACK: begin
        if (l2_ack) begin
          state_n = IDLE;
        end
      end
      REFILL: begin
        // Invalidations queued behind the refill start right after it.
        if (refill_done) begin
          take    = any_req;
          state_n = any_req ? LOOKUP : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_l1 or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      sel_data        <= 1'b0;
      inclusive_index <= '0;
    end else begin
      state <= state_n;
      if (take) begin
        sel_data        <= pick_data;
        inclusive_index <= pick_index;
      end
    end
  end

  assign refill_grant         = (state == REFILL);
  assign change_index_sel     = (state == LOOKUP);
  assign l2_clear_way         = (state == CLEAR)
                              ? (sel_data ? tag_hit_data : tag_hit_inst)
                              : '0;
  assign inst_replace_il1_ack = (state == ACK) & ~sel_data;
  assign data_replace_il1_ack = (state == ACK) & sel_data;
  assign busy                 = (state != IDLE) | pend;

endmodule
